// File: rtl/dcache_sram.sv
// Single-port word-addressed data SRAM with bit write enables, registered read,
// post-reset clear sweep (enabled by DCACHE_CLEAR_EN), ready and sticky error flags.
module dcache_sram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DADDR_WIDTH-1:0] dcache_addr,
  input  logic                   dcache_ceb,
  input  logic [DATA_WIDTH-1:0]  dcache_bweb,
  input  logic [DATA_WIDTH-1:0]  dcache_wdata,
  output logic [DATA_WIDTH-1:0]  dcache_rdata,
  output logic                   dcache_ready,
  output logic                   dcache_err
);

  localparam int unsigned DEPTH = 2 ** DADDR_WIDTH;

  // ST_INIT is the clear sweep when enabled, otherwise a single pending cycle.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   mem_we;
  logic [DADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wmask;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   rd_en;
  logic                   ready_nxt;
  logic                   err_nxt;

`ifdef DCACHE_CLEAR_EN
  logic [DADDR_WIDTH-1:0] cnt, cnt_nxt;
`endif

  // Next-state, write-port steering and flag updates.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = dcache_addr;
    mem_wmask = dcache_bweb;
    mem_wdata = dcache_wdata;
    rd_en     = 1'b0;
    ready_nxt = 1'b0;
    err_nxt   = dcache_err;
`ifdef DCACHE_CLEAR_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      ST_INIT: begin
        if (!dcache_ceb) err_nxt = 1'b1;
`ifdef DCACHE_CLEAR_EN
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wmask = '0;
        mem_wdata = '0;
        cnt_nxt   = cnt + DADDR_WIDTH'(1);
        if (cnt == '1) begin
          state_nxt = ST_RUN;
          ready_nxt = 1'b1;
        end
`else
        state_nxt = ST_RUN;
        ready_nxt = 1'b1;
`endif
      end
      ST_RUN: begin
        ready_nxt = 1'b1;
        if (!dcache_ceb) begin
          if (&dcache_bweb) rd_en  = 1'b1;
          else              mem_we = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      dcache_rdata <= '0;
      dcache_ready <= 1'b0;
      dcache_err   <= 1'b0;
`ifdef DCACHE_CLEAR_EN
      cnt          <= '0;
`endif
    end else begin
      state        <= state_nxt;
      dcache_ready <= ready_nxt;
      dcache_err   <= err_nxt;
      if (rd_en) dcache_rdata <= mem[dcache_addr];
`ifdef DCACHE_CLEAR_EN
      cnt          <= cnt_nxt;
`endif
    end
  end

  // Array is not reset; only bits with a low write mask change.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      mem[mem_waddr] <= (mem[mem_waddr] & mem_wmask) | (mem_wdata & ~mem_wmask);
  end

endmodule

// File: tb/tb_dcache_sram.sv
// Directed + randomized bench for dcache_sram (DADDR_WIDTH = 4) against a
// word-array reference model; honours DCACHE_CLEAR_EN.
module tb_dcache_sram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;
`ifdef DCACHE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
  localparam int CLR = 16;
`else
  localparam bit CLR_EN = 1'b0;
  localparam int CLR = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ceb = 1'b1;
  logic [DW-1:0] bweb = '1;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          err;

  dcache_sram #(.DATA_WIDTH(DW), .DADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .dcache_addr(addr), .dcache_ceb(ceb),
    .dcache_bweb(bweb), .dcache_wdata(wdata), .dcache_rdata(rdata),
    .dcache_ready(ready), .dcache_err(err)
  );

  always #5 clk = ~clk;

  // Reference model: word array with known flags, cycles since reset release.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  logic [DW-1:0] m_rdata;
  bit            m_rknown;
  bit            m_err;
  int            since;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [AW-1:0] a,
                      input logic [DW-1:0] be, input logic [DW-1:0] wd);
    bit rdy_pre;
    rst_n = r; ceb = c; addr = a; bweb = be; wdata = wd;
    @(posedge clk);
    #1;
    if (!r) begin
      m_rdata = '0; m_rknown = 1'b1; m_err = 1'b0; since = 0;
    end else begin
      rdy_pre = (since >= CLR);
      if (!rdy_pre) begin
        if (!c) m_err = 1'b1;
        since++;
        if (since == CLR && CLR_EN)
          for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b1; end
      end else if (!c) begin
        if (be == '1) begin
          m_rdata = m_mem[a]; m_rknown = m_known[a];
        end else begin
          m_mem[a] = (m_mem[a] & be) | (wd & ~be);
          m_known[a] = m_known[a] || (be == '0);
        end
      end
    end
    chk("ready", DW'(ready), DW'(since >= CLR));
    chk("err", DW'(err), DW'(m_err));
    if (m_rknown) chk("rdata", rdata, m_rdata);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, AW'($urandom), $urandom, $urandom);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, '1, $urandom);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] be, input logic [DW-1:0] wd);
    step(1'b1, 1'b0, a, be, wd);
  endtask

  // Counts cycles from release until ready; optional write to addr 2 at cycle err_cyc.
  task automatic release_and_wait(input int err_cyc, output int cycles);
    cycles = 0;
    for (int k = 1; k <= CLR + 8; k++) begin
      if (k == err_cyc) wr(AW'(2), '0, 32'hFFFF_FFFF);
      else idle();
      cycles = k;
      if (ready) break;
    end
  endtask

  initial begin
    int cyc;
    int sel;
    logic [DW-1:0] be;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
    m_rdata = '0; m_rknown = 1'b1; m_err = 1'b0; since = 0;

    step(1'b0, 1'b1, '0, '1, '0);
    step(1'b0, 1'b0, AW'(9), '0, 32'hFFFF_FFFF);
    chk("rst_rdata", rdata, '0);
    chk("rst_ready", DW'(ready), '0);
    chk("rst_err", DW'(err), '0);

    release_and_wait((CLR >= 3) ? 3 : 1, cyc);
    chk("clear_len", DW'(cyc), DW'(CLR));
    chk("err_set", DW'(err), 32'd1);
    rd(AW'(2));
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    chk("err_sticky", DW'(err), 32'd1);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), '0, $urandom);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));

    wr(AW'(5), 32'h0000_0000, 32'hDEAD_BEEF);
    wr(AW'(5), 32'hFFFF_FF00, 32'h0000_0011);
    wr(AW'(5), 32'hFFFF_0000, 32'h0000_2233);
    rd(AW'(5));
    chk("bhw_word", rdata, 32'hDEAD_2233);

    wr(AW'(3), '0, '0);
    rd(AW'(3));
    chk("raw_n", rdata, '0);
    wr(AW'(3), '0, 32'h1234_5678);
    chk("raw_hold", rdata, '0);
    rd(AW'(3));
    chk("raw_n2", rdata, 32'h1234_5678);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: be = 32'hFFFF_FF00;
        1: be = 32'hFFFF_0000;
        2: be = 32'h0000_0000;
        3: be = $urandom;
        default: be = '1;
      endcase
      step(1'b1, ($urandom_range(0, 5) == 0), AW'($urandom), be, $urandom);
    end

    rd(AW'(9));
    for (int k = 0; k < 50; k++) idle();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));

    wr(AW'(7), '0, 32'hA5A5_A5A5);
    rd(AW'(7));
    step(1'b0, 1'b1, AW'(7), '1, '0);
    chk("rst2_rdata", rdata, '0);
    chk("rst2_ready", DW'(ready), '0);
    chk("rst2_err", DW'(err), '0);
    release_and_wait(0, cyc);
    chk("clear_len2", DW'(cyc), DW'(CLR));
    rd(AW'(7));
    chk("addr7_after_rst", rdata, CLR_EN ? 32'h0 : 32'hA5A5_A5A5);
    chk("err_clean", DW'(err), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
